// File: rtl/picorv32_pcpi_pkg.sv
// Shared types and decode constants for the PCPI co-processor hub and its
// co-processor decoders.
package picorv32_pcpi_pkg;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    RESP  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    TGT_NONE = 2'd0,
    TGT_MUL  = 2'd1,
    TGT_DIV  = 2'd2
  } tgt_t;

endpackage

// File: rtl/picorv32_pcpi_hub_if.sv
// Bundle of core-side PCPI signals, the broadcast operand bus and the two
// co-processor request/response channels. The hub connects through 'slave'.
interface picorv32_pcpi_hub_if;

  // Handshake: a requester holds *_valid high with stable operands until the
  // responder pulses *_ready for one cycle; *_wait high means "claimed, still
  // working"; *_wr/*_rd are only meaningful in the *_ready cycle.
  logic        pcpi_valid;
  logic [31:0] pcpi_insn;
  logic [31:0] pcpi_rs1;
  logic [31:0] pcpi_rs2;
  logic        pcpi_wr;
  logic [31:0] pcpi_rd;
  logic        pcpi_wait;
  logic        pcpi_ready;
  logic        pcpi_timeout;

  logic [31:0] cp_insn;
  logic [31:0] cp_rs1;
  logic [31:0] cp_rs2;

  logic        mul_valid;
  logic        mul_wr;
  logic [31:0] mul_rd;
  logic        mul_wait;
  logic        mul_ready;

  logic        div_valid;
  logic        div_wr;
  logic [31:0] div_rd;
  logic        div_wait;
  logic        div_ready;

  modport slave (
    input  pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2,
    output pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready, pcpi_timeout,
    output cp_insn, cp_rs1, cp_rs2,
    output mul_valid, input mul_wr, mul_rd, mul_wait, mul_ready,
    output div_valid, input div_wr, div_rd, div_wait, div_ready
  );

  modport master (
    output pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2,
    input  pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready, pcpi_timeout,
    input  cp_insn, cp_rs1, cp_rs2,
    input  mul_valid, output mul_wr, mul_rd, mul_wait, mul_ready,
    input  div_valid, output div_wr, div_rd, div_wait, div_ready
  );

endinterface

// File: rtl/picorv32_pcpi_decode.sv
// Combinational instruction decode selecting which M-extension co-processor
// owns an instruction; funct3[2] splits MUL* from DIV*/REM*.
module picorv32_pcpi_decode
  import picorv32_pcpi_pkg::*;
(
  input  logic [6:0] i_opcode,
  input  logic [6:0] i_funct7,
  input  logic       i_funct3_msb,
  output tgt_t       o_tgt
);

  logic w_is_mop;

  assign w_is_mop = (i_opcode == OPC_OP) && (i_funct7 == F7_MULDIV);

  always_comb begin
    o_tgt = TGT_NONE;
    if (w_is_mop) begin
      o_tgt = i_funct3_msb ? TGT_DIV : TGT_MUL;
    end
  end

endmodule

// File: rtl/picorv32_pcpi_hub.sv
// PCPI hub: registers a core request, issues it to the multiplier or divider,
// returns the captured response as a one-cycle ready and flags unclaimed requests.
module picorv32_pcpi_hub
  import picorv32_pcpi_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                clk,
  input  logic                reset,
  picorv32_pcpi_hub_if.slave  pcpi,
  output state_t              o_state
);

  localparam int             CW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0]  CNT_MAX  = '1;

  state_t        r_state;
  tgt_t          r_tgt;
  logic [CW-1:0] r_cnt;
  logic [31:0]   r_insn;
  logic [31:0]   r_rs1;
  logic [31:0]   r_rs2;
  logic [31:0]   r_rd;
  logic          r_wr;

  tgt_t        w_dec_tgt;
  logic        w_busy;
  logic        w_sel_ready;
  logic        w_sel_wait;
  logic        w_sel_wr;
  logic [31:0] w_sel_rd;
  logic        w_timeout;

  picorv32_pcpi_decode u_decode (
    .i_opcode     (pcpi.pcpi_insn[6:0]),
    .i_funct7     (pcpi.pcpi_insn[31:25]),
    .i_funct3_msb (pcpi.pcpi_insn[14]),
    .o_tgt        (w_dec_tgt)
  );

  // Only the latched target is listened to; the other channel is ignored.
  always_comb begin
    w_sel_ready = 1'b0;
    w_sel_wait  = 1'b0;
    w_sel_wr    = 1'b0;
    w_sel_rd    = '0;
    case (r_tgt)
      TGT_MUL: begin
        w_sel_ready = pcpi.mul_ready;
        w_sel_wait  = pcpi.mul_wait;
        w_sel_wr    = pcpi.mul_wr;
        w_sel_rd    = pcpi.mul_rd;
      end
      TGT_DIV: begin
        w_sel_ready = pcpi.div_ready;
        w_sel_wait  = pcpi.div_wait;
        w_sel_wr    = pcpi.div_wr;
        w_sel_rd    = pcpi.div_rd;
      end
      default: ;
    endcase
  end

  assign w_busy    = (r_state == BUSY);
  assign w_timeout = w_busy && pcpi.pcpi_valid && !w_sel_ready && !w_sel_wait &&
                     (r_cnt == CNT_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_tgt   <= TGT_NONE;
      r_cnt   <= '0;
      r_insn  <= '0;
      r_rs1   <= '0;
      r_rs2   <= '0;
      r_rd    <= '0;
      r_wr    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (pcpi.pcpi_valid) begin
            r_insn  <= pcpi.pcpi_insn;
            r_rs1   <= pcpi.pcpi_rs1;
            r_rs2   <= pcpi.pcpi_rs2;
            r_tgt   <= w_dec_tgt;
            r_cnt   <= '0;
            r_state <= BUSY;
          end
        end
        BUSY: begin
          // Core abort outranks a same-cycle ready; ready outranks timeout.
          if (!pcpi.pcpi_valid) begin
            r_state <= DRAIN;
          end else if (w_sel_ready) begin
            r_rd    <= w_sel_rd;
            r_wr    <= w_sel_wr;
            r_state <= RESP;
          end else if (w_sel_wait) begin
            r_cnt <= '0;
          end else if (w_timeout) begin
            r_state <= DRAIN;
          end else if (r_cnt != CNT_MAX) begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        RESP: begin
          r_state <= DRAIN;
        end
        DRAIN: begin
          // Wait for the core to drop valid so the same insn is not re-issued.
          if (!pcpi.pcpi_valid) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign pcpi.cp_insn      = r_insn;
  assign pcpi.cp_rs1       = r_rs1;
  assign pcpi.cp_rs2       = r_rs2;
  assign pcpi.mul_valid    = w_busy && (r_tgt == TGT_MUL);
  assign pcpi.div_valid    = w_busy && (r_tgt == TGT_DIV);
  assign pcpi.pcpi_wait    = ((r_state == BUSY) || (r_state == RESP)) && (r_tgt != TGT_NONE);
  assign pcpi.pcpi_ready   = (r_state == RESP);
  assign pcpi.pcpi_rd      = (r_state == RESP) ? r_rd : '0;
  assign pcpi.pcpi_wr      = (r_state == RESP) && r_wr;
  assign pcpi.pcpi_timeout = w_timeout;
  assign o_state           = r_state;

endmodule
